// File: rtl/cpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared definitions for the CPU state dumper: stream tag values, the frame
// length and the dumper FSM state type.
// -----------------------------------------------------------------------------
package cpu_dbg_pkg;

  // Stream tags carried on out_tag_o alongside each frame word.
  localparam logic [5:0] TAG_FRAME = 6'd0;   // frame number header
  localparam logic [5:0] TAG_PC    = 6'd1;   // latched PC
  localparam logic [5:0] TAG_REG0  = 6'd2;   // R0; R(n) uses TAG_REG0 + n
  localparam logic [5:0] TAG_MEM0  = 6'd34;  // DMEM word 0; word w uses TAG_MEM0 + w
  localparam logic [5:0] TAG_LAST  = 6'd41;  // final word of a frame

  // Words per frame: header + PC + 32 registers + 8 memory words.
  localparam int FRAME_WORDS = 42;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PCW  = 3'd2,
    S_REG  = 3'd3,
    S_MRD  = 3'd4,
    S_MOUT = 3'd5
  } dump_state_e;

endpackage

// File: rtl/dmem_word_gather.sv
// -----------------------------------------------------------------------------
// dmem_word_gather
// Reads one 32-bit little-endian word through the data-memory debug byte port
// over four consecutive enabled cycles.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-low
//   en_i         in   gather active; one byte is captured per enabled cycle
//   word_i       in   word index being gathered
//   byte_addr_o  out  debug byte address {word_i, byte}; 0 when idle
//   byte_i       in   byte read data, combinational from byte_addr_o
//   word_o       out  assembled word, valid after done_o
//   done_o       out  high on the cycle the fourth byte is captured
// -----------------------------------------------------------------------------
module dmem_word_gather (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [2:0]  word_i,
  output logic [4:0]  byte_addr_o,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;

  // The 2-bit counter wraps 3 -> 0 by itself, so it is ready for the next word.
  assign byte_d      = en_i ? byte_q + 2'd1 : byte_q;
  assign byte_addr_o = en_i ? {word_i, byte_q} : 5'd0;
  assign done_o      = en_i && (byte_q == 2'd3);
  assign word_o      = word_q;

  // One write lane per byte position: byte b lands in bits [8b+7:8b].
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word_d[8*gi +: 8] = (en_i && (byte_q == 2'(gi))) ? byte_i : word_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_q <= 2'd0;
      word_q <= 32'd0;
    end else begin
      byte_q <= byte_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/cpu_state_dumper.sv
// -----------------------------------------------------------------------------
// cpu_state_dumper
// On a dump request, stalls the CPU and streams one tagged frame:
// frame number, PC, all registers, then the data-memory words, over a
// valid/ready interface.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous reset, active-low
//   dump_i       in   dump request (ignored while busy or halted)
//   pc_i         in   current CPU PC, latched when a dump is accepted
//   reg_addr_o   out  register-file debug read address
//   reg_data_i   in   register read data (combinational from reg_addr_o)
//   dmem_addr_o  out  data-memory debug byte address
//   dmem_data_i  in   data-memory byte (combinational from dmem_addr_o)
//   out_valid_o  out  stream word valid
//   out_ready_i  in   stream consumer ready
//   out_data_o   out  stream word
//   out_tag_o    out  stream word tag
//   out_last_o   out  high with the final word of a frame
//   stall_o      out  high while a frame is in progress
//   halt_o       out  sticky; high once MAX_FRAMES frames are completed
//   frame_cnt_o  out  completed-frame count (saturating)
// -----------------------------------------------------------------------------
module cpu_state_dumper
  import cpu_dbg_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DMEM_WORDS = 8,
  parameter int MAX_FRAMES = 30
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dump_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [4:0]  dmem_addr_o,
  input  logic [7:0]  dmem_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [5:0]  out_tag_o,
  output logic        out_last_o,
  output logic        stall_o,
  output logic        halt_o,
  output logic [7:0]  frame_cnt_o
);

  localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
  localparam logic [2:0] LAST_WORD = 3'(DMEM_WORDS - 1);
  localparam logic [7:0] HALT_CNT  = 8'(MAX_FRAMES);

  dump_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  reg_idx_q, reg_idx_d;
  logic        reg_loaded_q, reg_loaded_d;
  logic [31:0] reg_buf_q, reg_buf_d;
  logic [2:0]  word_idx_q, word_idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        halt_q, halt_d;

  logic        xfer;
  logic [7:0]  cnt_inc;
  logic        gather_en;
  logic        gather_done;
  logic [31:0] gather_word;

  assign gather_en = (state_q == S_MRD);

  dmem_word_gather u_gather (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (gather_en),
    .word_i      (word_idx_q),
    .byte_addr_o (dmem_addr_o),
    .byte_i      (dmem_data_i),
    .word_o      (gather_word),
    .done_o      (gather_done)
  );

  // All stream outputs decode from registers only, so they cannot change
  // while a word waits for out_ready_i.
  always_comb begin
    out_valid_o = 1'b0;
    out_data_o  = 32'd0;
    out_tag_o   = TAG_FRAME;
    out_last_o  = 1'b0;
    case (state_q)
      S_HDR: begin
        out_valid_o = 1'b1;
        out_data_o  = {24'd0, frame_cnt_q};
        out_tag_o   = TAG_FRAME;
      end
      S_PCW: begin
        out_valid_o = 1'b1;
        out_data_o  = pc_q;
        out_tag_o   = TAG_PC;
      end
      S_REG: begin
        // First cycle of each register loads the buffer; valid follows.
        out_valid_o = reg_loaded_q;
        out_data_o  = reg_buf_q;
        out_tag_o   = TAG_REG0 + {1'b0, reg_idx_q};
      end
      S_MOUT: begin
        out_valid_o = 1'b1;
        out_data_o  = gather_word;
        out_tag_o   = TAG_MEM0 + {3'd0, word_idx_q};
        out_last_o  = (word_idx_q == LAST_WORD);
      end
      default: ;
    endcase
  end

  assign xfer        = out_valid_o && out_ready_i;
  assign reg_addr_o  = reg_idx_q;
  assign stall_o     = (state_q != S_IDLE);
  assign halt_o      = halt_q;
  assign frame_cnt_o = frame_cnt_q;
  assign cnt_inc     = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    reg_idx_d    = reg_idx_q;
    reg_loaded_d = reg_loaded_q;
    reg_buf_d    = reg_buf_q;
    word_idx_d   = word_idx_q;
    frame_cnt_d  = frame_cnt_q;
    halt_d       = halt_q;
    case (state_q)
      S_IDLE: begin
        if (dump_i && !halt_q) begin
          pc_d    = pc_i;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) state_d = S_PCW;
      end
      S_PCW: begin
        if (xfer) begin
          state_d      = S_REG;
          reg_idx_d    = 5'd0;
          reg_loaded_d = 1'b0;
        end
      end
      S_REG: begin
        if (!reg_loaded_q) begin
          reg_buf_d    = reg_data_i;
          reg_loaded_d = 1'b1;
        end else if (xfer) begin
          reg_loaded_d = 1'b0;
          if (reg_idx_q == LAST_REG) begin
            state_d    = S_MRD;
            reg_idx_d  = 5'd0;
            word_idx_d = 3'd0;
          end else begin
            reg_idx_d = reg_idx_q + 5'd1;
          end
        end
      end
      S_MRD: begin
        if (gather_done) state_d = S_MOUT;
      end
      S_MOUT: begin
        if (xfer) begin
          if (word_idx_q == LAST_WORD) begin
            state_d     = S_IDLE;
            word_idx_d  = 3'd0;
            frame_cnt_d = cnt_inc;
            if (cnt_inc == HALT_CNT) halt_d = 1'b1;
          end else begin
            word_idx_d = word_idx_q + 3'd1;
            state_d    = S_MRD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      pc_q         <= 32'd0;
      reg_idx_q    <= 5'd0;
      reg_loaded_q <= 1'b0;
      reg_buf_q    <= 32'd0;
      word_idx_q   <= 3'd0;
      frame_cnt_q  <= 8'd0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      reg_idx_q    <= reg_idx_d;
      reg_loaded_q <= reg_loaded_d;
      reg_buf_q    <= reg_buf_d;
      word_idx_q   <= word_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      halt_q       <= halt_d;
    end
  end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Hardware counterpart of the bench-side state dump: on a trigger, stalls the single-cycle CPU, reads PC, all registers and the data-memory words, and streams them out as one tagged 42-word frame on a valid/ready interface.
- Sits beside CPU: drives the register-file debug read port and the data-memory debug byte port. Its stall output gates the CPU start input.
- Consumers are the trace UART/packer and the verification scoreboard.

Parameters:
NUM_REGS, 32, register-file entries dumped (tags 2..NUM_REGS+1)
DMEM_WORDS, 8, little-endian 32-bit data-memory words dumped (bytes 0..4*DMEM_WORDS-1)
MAX_FRAMES, 30, completed frames after which halt_o asserts and further triggers are ignored

Ports:
clk_i        in   1   clock, rising edge
rst_i        in   1   asynchronous reset, active-low
dump_i       in   1   dump request, sampled each cycle
pc_i         in   32  current CPU PC
reg_addr_o   out  5   register debug read address
reg_data_i   in   32  register read data, combinational from reg_addr_o
dmem_addr_o  out  5   data-memory debug byte address
dmem_data_i  in   8   data-memory byte, combinational from dmem_addr_o
out_valid_o  out  1   stream word valid
out_ready_i  in   1   stream consumer ready
out_data_o   out  32  stream word
out_tag_o    out  6   0=frame number, 1=PC, 2..33=R0..R31, 34..41=DMEM word 0..7
out_last_o   out  1   high with tag 41
stall_o      out  1   high while a frame is in progress; CPU must hold state
halt_o       out  1   sticky, high once MAX_FRAMES frames are completed
frame_cnt_o  out  8   completed-frame count

Behaviour:
- Reset (rst_i=0, async): FSM to IDLE. All outputs go to 0, including frame_cnt_o, halt_o, the address outputs and the tag.
- Handshake:
  - A word transfers on a cycle where out_valid_o && out_ready_i.
  - While out_valid_o=1 and out_ready_i=0, out_data_o, out_tag_o and out_last_o are held stable.
  - out_valid_o never drops without a transfer.
- FSM: IDLE -> HDR -> PCW -> REG -> MRD -> MOUT -> IDLE.
- IDLE:
  - dump_i=1 and halt_o=0: latch pc_i into an internal register, set stall_o=1 in the next cycle, go to HDR.
  - dump_i while busy or halted: ignored, not queued.
- HDR: present {24'b0, frame_cnt_o} with tag 0. On transfer, go to PCW.
- PCW: present the latched PC with tag 1. On transfer, go to REG with register index 0.
- REG:
  - reg_addr_o = index; out_data_o loads reg_data_i; tag = index+2.
  - On each transfer, increment index. After index NUM_REGS-1 transfers, go to MRD with word 0.
  - Each register costs at least 1 load cycle plus the transfer. Pipelining the next load on the transfer cycle is allowed, provided the held-stable rule is kept.
- MRD:
  - 4 cycles; byte b = 0..3.
  - dmem_addr_o = 4*word+b.
  - Assemble dmem_data_i into bits [8b+7:8b] (little-endian, i.e. {m[4w+3], m[4w+2], m[4w+1], m[4w]}).
  - Then go to MOUT.
- MOUT: present the assembled word with tag 34+word; out_last_o=1 when word = DMEM_WORDS-1. On transfer:
  - More words remain: word+1, back to MRD.
  - Last word: frame_cnt_o+1, go to IDLE, stall_o=0 in the following cycle.
  - If the new count equals MAX_FRAMES, set halt_o (sticky until reset).
- Minimum frame latency with out_ready_i held at 1: 1 (accept) + 2 (HDR, PCW) + 2*NUM_REGS + 5*DMEM_WORDS, i.e. 107 cycles from dump_i to the cycle after the out_last_o transfer.
- frame_cnt_o saturates at 255. It does not wrap; halt_o normally prevents reaching this.
- stall_o is 0 in IDLE and 1 in every other state.
- Reset mid-frame: the frame is abandoned and no partial out_last_o is issued. stall_o drops asynchronously with reset.

Decomposition:
- Shared package cpu_dbg_pkg:
  - Tag constants TAG_FRAME=0, TAG_PC=1, TAG_REG0=2, TAG_MEM0=34, TAG_LAST=41.
  - FSM state enum.
  - Frame length constant (42).
- One sub-module: dmem_word_gather (byte counter plus 32-bit little-endian assembler with done pulse), used by MRD.

Test Plan:
- Single dump with pc_i=0x0000_0018, R8=5, R31=0x1234, DMEM bytes 0..3 = 05,00,00,00, out_ready_i=1 -> expected stream:
  - 42 words, in order tag 0 (data 0), tag 1 (0x18), tag 10 (5), tag 33 (0x1234), tag 34 (5), with out_last_o only on tag 41.
  - Frame ends 107 cycles after dump_i; frame_cnt_o=1.
- Endianness: DMEM bytes 4..7 = 0xEF,0xBE,0xAD,0xDE -> tag 35 word = 0xDEADBEEF.
- Backpressure: toggle out_ready_i pseudo-randomly (50%) -> identical 42-word sequence; data and tag held stable during every stall; stall_o=1 throughout.
- dump_i pulsed at cycles 3, 10 and 50 of a frame -> exactly one frame emitted; the next dump after IDLE yields header data 1.
- MAX_FRAMES=2 (overridden): three dumps -> two frames, halt_o rises the cycle after the second out_last_o transfer, third dump ignored with stall_o=0.
- Assert rst_i=0 during the REG phase (tag 15 pending) -> out_valid_o, stall_o and frame_cnt_o go to 0 immediately. After release, a new dump starts at tag 0 with header 0.
